fb_arbiter: RTL

Arbitrates the single DDR2 frame-buffer command port between the display scanout reader and the ray-tracer pixel writer. It sits between the two requesters and the frame-buffer memory interface, and keeps at most one transaction outstanding. Display reads have fixed priority. A starvation counter guarantees the renderer forward progress.

---
 rtl/fb_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fb_arbiter.sv
// fb_arbiter: arbitrates the single DDR2 frame-buffer command port between
// the display scanout reader (fixed priority) and the ray-tracer pixel writer.
// At most one transaction is outstanding at any time. A starvation counter
// forces a render write through after STARVE_LIMIT consecutive display grants.
//
// Optional feature: define FB_ARB_WDOG_EN to enable the read-return watchdog.
// It aborts a read after WDOG_CYCLES cycles in RD_WAIT, sets the sticky err
// flag and returns zero data. When the macro is undefined, err is tied low and
// no counter logic is generated.

module fb_arbiter #(
  parameter int ADDR_W       = 27,
  parameter int DATA_W       = 128,
  parameter int STARVE_LIMIT = 8,
  parameter int WDOG_CYCLES  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  // display read requester
  input  logic                  disp_req,
  input  logic [ADDR_W-1:0]     disp_addr,
  output logic                  disp_gnt,
  output logic                  disp_valid,
  output logic [DATA_W-1:0]     disp_rdata,
  // render write requester
  input  logic                  rt_req,
  input  logic [ADDR_W-1:0]     rt_addr,
  input  logic [DATA_W-1:0]     rt_wdata,
  input  logic [DATA_W/8-1:0]   rt_wmask,
  output logic                  rt_gnt,
  // frame-buffer memory interface
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [2:0]            mem_cmd,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_rdy,
  input  logic                  mem_valid,
  input  logic [DATA_W-1:0]     mem_dout,
  // status
  output logic                  err
);

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    WR_ISSUE = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_disp_wins;
  logic             w_starved;

`ifdef FB_ARB_WDOG_EN
  localparam int                 WD_W     = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0]    WD_LAST  = WD_W'(WDOG_CYCLES - 1);
  logic [WD_W-1:0] r_wdog_cnt;
  logic            r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  // Grants are combinational so the requester sees acceptance in the same
  // cycle the memory takes the command.
  assign disp_gnt = (r_state == RD_ISSUE) && mem_rdy;
  assign rt_gnt   = (r_state == WR_ISSUE) && mem_rdy;

  // Display keeps priority until the renderer has been passed over
  // STARVE_LIMIT times in a row.
  assign w_starved   = (r_starve_cnt >= LIMIT_C);
  assign w_disp_wins = disp_req && (!w_starved || !rt_req);

  // Main FSM with registered memory-side outputs and read-return capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      mem_addr     <= '0;
      mem_cmd      <= '0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      mem_wdata    <= '0;
      mem_wmask    <= '0;
      disp_valid   <= 1'b0;
      // NOTE: the wide data registers are reset too, because the outputs
      // must read as zero while reset is applied, not just the control bits.
      disp_rdata   <= '0;
`ifdef FB_ARB_WDOG_EN
      r_wdog_cnt   <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      // NOTE: every state register here uses <= so all updates see the
      // pre-edge values, exactly like the flops they become.
      disp_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_disp_wins) begin
            mem_addr    <= disp_addr;
            mem_cmd     <= CMD_RD;
            mem_read_en <= 1'b1;
            r_state     <= RD_ISSUE;
          end else if (rt_req) begin
            mem_addr     <= rt_addr;
            mem_wdata    <= rt_wdata;
            mem_wmask    <= rt_wmask;
            mem_cmd      <= CMD_WR;
            mem_write_en <= 1'b1;
            r_state      <= WR_ISSUE;
          end
        end

        RD_ISSUE: begin
          if (mem_rdy) begin
            mem_read_en <= 1'b0;
            r_state     <= RD_WAIT;
`ifdef FB_ARB_WDOG_EN
            r_wdog_cnt  <= '0;
`endif
          end
        end

        RD_WAIT: begin
          if (mem_valid) begin
            disp_rdata <= mem_dout;
            disp_valid <= 1'b1;
            r_state    <= IDLE;
`ifdef FB_ARB_WDOG_EN
          end else if (r_wdog_cnt == WD_LAST) begin
            // Give up on the read: flag it and hand back zero data.
            r_err      <= 1'b1;
            disp_rdata <= '0;
            disp_valid <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
`endif
          end
        end

        WR_ISSUE: begin
          if (mem_rdy) begin
            mem_write_en <= 1'b0;
            r_state      <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  // Starvation counter: counts display grants taken while a write waits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (rt_gnt) begin
      r_starve_cnt <= '0;
    end else if ((r_state == IDLE) && !rt_req) begin
      r_starve_cnt <= '0;
    end else if (disp_gnt && rt_req && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule
